// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES main-memory arbiter, the CPU/PPU requesters and the memory model.
package nes_mem_pkg;

    localparam int AW_DEF  = 16;
    localparam int DW_DEF  = 8;
    localparam int LAT_DEF = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/nes_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view, master the environment's.
interface nes_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ppu_req;
    logic [AW-1:0] ppu_addr;
    logic          ppu_ack;
    logic          ppu_rvalid;
    logic [DW-1:0] ppu_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        input  ppu_req, ppu_addr,
        output ppu_ack, ppu_rvalid, ppu_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        output ppu_req, ppu_addr,
        input  ppu_ack, ppu_rvalid, ppu_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/nes_mem_tagpipe.sv
// Owner-code delay line: one entry per issued memory cycle, tail aligns with returning read data.
module nes_mem_tagpipe
    import nes_mem_pkg::*;
#(
    parameter int DEPTH = LAT_DEF + 1
) (
    input  logic   clk,
    input  logic   clr,
    input  owner_e push,
    output owner_e tail
);

    owner_e pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: this small array is cleared because a stale tag would fire a spurious rvalid;
            // bulk data storage would normally be left unreset.
            for (int i = 0; i < DEPTH; i++) pipe[i] <= OWN_NONE;
        end else begin
            pipe[0] <= push;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[DEPTH-1];

endmodule

// File: rtl/nes_mem_arbiter.sv
// CPU/PPU arbiter for the single-port NES main memory: PPU priority with a bounded CPU-starvation streak.
module nes_mem_arbiter
    import nes_mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int LAT     = LAT_DEF,
    parameter int PPU_MAX = 3
) (
    input  logic               clk,
    input  logic               reset,
    nes_mem_arbiter_if.slave   bus
);

    localparam logic [3:0] STREAK_MAX = 4'(PPU_MAX);

    logic          cpu_grant;
    logic          ppu_grant;
    logic [3:0]    streak;
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
    owner_e        push_owner;
    owner_e        tail_owner;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        cpu_grant  = 1'b0;
        ppu_grant  = 1'b0;
        push_owner = OWN_NONE;
        if (!reset) begin
            if (bus.ppu_req && (!bus.cpu_req || streak != STREAK_MAX)) begin
                ppu_grant  = 1'b1;
                push_owner = OWN_PPU;
            end else if (bus.cpu_req) begin
                cpu_grant  = 1'b1;
                push_owner = bus.cpu_we ? OWN_NONE : OWN_CPU;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            streak      <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            // Streak only measures PPU wins over a waiting CPU.
            if (cpu_grant || !bus.cpu_req) begin
                streak <= '0;
            end else if (ppu_grant && streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end

            mem_we_q <= cpu_grant && bus.cpu_we;
            if (cpu_grant) begin
                mem_addr_q  <= bus.cpu_addr;
                mem_wdata_q <= bus.cpu_wdata;
            end else if (ppu_grant) begin
                mem_addr_q  <= bus.ppu_addr;
            end
        end
    end

    nes_mem_tagpipe #(
        .DEPTH (LAT + 1)
    ) u_tagpipe (
        .clk  (clk),
        .clr  (reset),
        .push (push_owner),
        .tail (tail_owner)
    );

    assign bus.cpu_ack    = cpu_grant;
    assign bus.ppu_ack    = ppu_grant;
    // Gated by reset so responses already in flight vanish in the reset cycle itself.
    assign bus.cpu_rvalid = !reset && (tail_owner == OWN_CPU);
    assign bus.ppu_rvalid = !reset && (tail_owner == OWN_PPU);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.ppu_rdata  = bus.mem_rdata;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/nes_mem_arbiter.md
# nes_mem_arbiter

Two-port arbiter that shares the single-port NES main memory (64 KiB, 8-bit, fixed read latency) between the CPU and the PPU. It sits between the `cpu` / `ppu` instances and the memory array, issues at most one access per clock, tags each in-flight read with its owner, and routes returned data to the correct requester. The PPU has priority for real-time fetches; a streak limit bounds CPU starvation.

## Interface
Parameters:
- AW, 16, address width
- DW, 8, data width
- LAT, 2, memory read latency in clocks from `mem_addr` presented to `mem_rdata` valid; legal 1..4
- PPU_MAX, 3, maximum consecutive PPU grants while `cpu_req` is pending; legal 1..15

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held with address/data until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- ppu_req  in  1  PPU read request (PPU never writes)
- ppu_addr  in  AW  PPU address
- ppu_ack  out  1  request accepted this cycle (combinational)
- ppu_rvalid  out  1  PPU read data valid
- ppu_rdata  out  DW  PPU read data
- mem_addr  out  AW  registered memory address
- mem_we  out  1  registered write strobe
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  memory read data, LAT clocks after address

## Operation
- Each cycle N: at most one of `cpu_ack`/`ppu_ack` high. Both reqs high: PPU wins unless `streak == PPU_MAX`, then CPU wins. Single requester always wins.
- `streak` (4-bit): +1 on PPU grant while `cpu_req`=1; cleared on CPU grant or when `cpu_req`=0; saturates at PPU_MAX.
- Granted access registered into `mem_addr/mem_we/mem_wdata` at end of N, presented during N+1. No grant: `mem_we`=0, `mem_addr` holds last value.
- Tag pipeline, depth LAT+1, 2-bit owner code (NONE/CPU/PPU): reads push owner, writes and idle push NONE.
- Tag at output = CPU → `cpu_rvalid`=1; = PPU → `ppu_rvalid`=1. `cpu_rdata` and `ppu_rdata` both driven from `mem_rdata` unconditionally; valid only with the rvalid strobe.
- Requester keeps req/addr/data stable until ack; dropping req before ack is legal and cancels without side effect.
- Back-to-back grants to one requester are allowed every cycle; read responses return in grant order.

## Timing
- Grant in N → memory access in N+1 → `*_rvalid` in N+1+LAT (N+3 for LAT=2).
- Write granted in N is committed by memory at the end of N+1; a read granted in N+1 or later to the same address returns new data.
- Reset values: `cpu_ack`=`ppu_ack`=0, `cpu_rvalid`=`ppu_rvalid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `streak`=0, all tags NONE.
- Reset high in any cycle: acks forced 0 that cycle; in-flight reads dropped — no rvalid in any cycle after reset asserts until a new grant is made after reset deasserts.
- No throughput loss: sustained single requester gets 1 access/clock.

## Structure
- Package `nes_mem_pkg`: owner enum (OWN_NONE, OWN_CPU, OWN_PPU), default AW/DW/LAT constants shared with `cpu`, `ppu` and the top-level memory model.
- One sub-module: `nes_mem_tagpipe` — parameterised LAT+1-deep shift register of owner codes with synchronous clear; arbitration and streak logic stay in the top module.

## Test plan
- CPU-only read of 0x8000 holding 0xA9, ack at cycle 10 → `mem_addr`=0x8000 at 11, `cpu_rvalid`=1, `cpu_rdata`=0xA9 at 13; `ppu_rvalid` stays 0.
- CPU write 0x0200←0x55 granted at 10, CPU read 0x0200 granted at 11 → `mem_we`=1 at 11, read returns 0x55 at 14.
- Both requesting continuously, PPU_MAX=3 → grant sequence PPU,PPU,PPU,CPU repeating; CPU wait never exceeds 3 cycles.
- PPU reads 0x2000..0x2003 on consecutive cycles interleaved with one CPU read → each rvalid strobe on correct port, data in issue order, no lost or duplicated strobes.
- Reset asserted for one cycle with 2 reads in flight → no rvalid on either port afterwards; all outputs at reset values; next grant behaves as from reset.
- `cpu_req` dropped before ack while PPU streaming → no CPU access issued, `streak` clears, PPU continues at 1 access/clock.
